// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller for the 16-bit combinational ALU: fetches operands from
// a 16x16 register file, drives the ALU, and retires results, SWAP and error/overflow flags.
module alu_issue_ctrl #(
    parameter int NREGS = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [15:0]   instr,
    output logic [3:0]    alu_operation,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] alu_remainder,
    input  logic          alu_o,
    output logic          done,
    output logic          err,
    output logic          ovf_flag,
    output logic [DW-1:0] rem_reg,
    input  logic [3:0]    dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [1:0]    dbg_state
);

    // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
    // instr_ready is high only in IDLE and instr is ignored at all other times.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SWAP2 = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_MOV  = 4'h5;
    localparam logic [3:0] OP_SWAP = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;

    state_t          state_q, state_d;
    logic [15:0]     instr_q, instr_d;
    logic [3:0]      op_q, op_d;
    logic [DW-1:0]   op1_q, op1_d;
    logic [DW-1:0]   op2_q, op2_d;
    logic [DW-1:0]   swap_q, swap_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic [DW-1:0]   regs_q [NREGS];

    logic            wr_en;
    logic [3:0]      wr_addr;
    logic [DW-1:0]   wr_data;

    logic [3:0]      opc;
    logic [3:0]      rd;
    logic [3:0]      rs;
    logic [7:0]      imm8;

    assign opc  = instr_q[15:12];
    assign rd   = instr_q[11:8];
    assign rs   = instr_q[7:4];
    assign imm8 = instr_q[7:0];

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        op_d    = op_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        swap_d  = swap_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        wr_en   = 1'b0;
        wr_addr = rd;
        wr_data = alu_result;

        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    op_d    = (instr[15:12] >= OP_ADD && instr[15:12] <= OP_XOR) ? instr[15:12] : OP_NOP;
                    op1_d   = regs_q[instr[7:4]];
                    op2_d   = regs_q[instr[3:0]];
                    // Old rd is captured now because EXEC overwrites it before SWAP2 runs.
                    swap_d  = regs_q[instr[11:8]];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                done_d  = 1'b1;
                case (opc)
                    OP_NOP: ;
                    OP_ADD: begin
                        wr_en = 1'b1;
                        ovf_d = (op1_q[DW-1] == op2_q[DW-1]) && (alu_result[DW-1] != op1_q[DW-1]);
                    end
                    OP_SUB: begin
                        wr_en = 1'b1;
                        ovf_d = (op1_q[DW-1] != op2_q[DW-1]) && (alu_result[DW-1] != op1_q[DW-1]);
                    end
                    OP_MUL: begin
                        wr_en = 1'b1;
                        ovf_d = alu_o;
                    end
                    OP_DIV: begin
                        if (op2_q != '0) begin
                            wr_en = 1'b1;
                            rem_d = alu_remainder;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    OP_MOV, OP_AND, OP_OR, OP_XOR: wr_en = 1'b1;
                    OP_SWAP: begin
                        wr_en   = 1'b1;
                        wr_data = op1_q;
                        done_d  = 1'b0;
                        state_d = SWAP2;
                    end
                    OP_LDI: begin
                        wr_en   = 1'b1;
                        wr_data = {{(DW-8){imm8[7]}}, imm8};
                    end
                    default: err_d = 1'b1;
                endcase
            end
            SWAP2: begin
                wr_en   = 1'b1;
                wr_addr = rs;
                wr_data = swap_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            op_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            swap_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            op_q    <= op_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            swap_q  <= swap_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    assign instr_ready   = (state_q == IDLE);
    assign alu_operation = op_q;
    assign alu_op1       = op1_q;
    assign alu_op2       = op2_q;
    assign done          = done_q;
    assign err           = err_q;
    assign ovf_flag      = ovf_q;
    assign rem_reg       = rem_q;
    assign dbg_data      = regs_q[dbg_addr];
    assign dbg_state     = state_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Instruction-level initiator for the 16-bit ALU: accepts one 16-bit instruction at a time over a valid/ready handshake and reads operands from an internal 16x16 register file. It drives the ALU operation and operand inputs, then writes the ALU result (and, for DIV, the remainder) back. It sits between the instruction source and the combinational ALU and owns all sequencing, write-back, SWAP, and error and overflow flagging.

Parameters:
NREGS, 16, register file depth; fixed at 16 because the instruction has 4-bit register fields.
DW, 16, data width; must match the ALU operand width.

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction present
instr_ready  out  1  controller can accept an instruction
instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt; [7:0] imm8 for LDI
alu_operation  out  4  registered opcode to ALU
alu_op1  out  16  registered operand 1 (regfile[rs])
alu_op2  out  16  registered operand 2 (regfile[rt])
alu_result  in  16  ALU result
alu_remainder  in  16  ALU remainder
alu_o  in  1  ALU overflow indication
done  out  1  one-cycle pulse: instruction retired
err  out  1  one-cycle pulse with done: illegal opcode or divide-by-zero
ovf_flag  out  1  overflow status of last ADD/SUB/MUL
rem_reg  out  16  remainder of last successful DIV
dbg_addr  in  4  debug read address
dbg_data  out  16  regfile[dbg_addr], combinational

Behaviour:
- One clock domain. Reset is synchronous and active-high. The clock and reset ports are named clk and reset.
- Reset values: state IDLE, all 16 registers 0, alu_operation/alu_op1/alu_op2 0, done 0, err 0, ovf_flag 0, rem_reg 0. Reset wins over every other event, including mid-EXEC and mid-SWAP2; no write-back completes in the reset cycle.
- Opcodes:
  - 0000 NOP
  - 0001 ADD, 0010 SUB, 0011 MUL, 0100 DIV
  - 0101 MOV: rd <= rs
  - 0110 SWAP: rd <-> rs
  - 0111 AND, 1000 OR, 1001 XOR
  - 1010 LDI: rd <= sign-extended imm8
  - 1011-1111 illegal
- States: IDLE, EXEC, SWAP2.
- IDLE: instr_ready=1. When instr_valid is high at a clock edge:
  - latch the instruction;
  - load alu_operation=opcode for 0001-1001, else 0000;
  - load alu_op1=regfile[rs] and alu_op2=regfile[rt];
  - go to EXEC.
- EXEC (instr_ready=0): the ALU outputs are stable. At the end of the cycle:
  - 0001-0101, 0111-1001: rd <= alu_result.
  - MUL: rem_reg is not updated.
  - DIV with alu_op2 != 0: rd <= alu_result, rem_reg <= alu_remainder.
  - DIV with alu_op2 == 0: no register write, rem_reg held, err pulse.
  - LDI: rd <= {{8{imm8[7]}}, imm8}; the ALU output is ignored.
  - NOP: no write.
  - Illegal opcode: no write, err pulse.
  - SWAP: rd <= alu_op1 (old rs value), then go to SWAP2. All other opcodes return to IDLE.
- SWAP2: rs <= old rd value, latched at accept; return to IDLE. When rd == rs, the register is unchanged.
- done and err are registered. They are high in the first IDLE cycle after the final write. A new instruction may be accepted in that same cycle, and its operand read sees the completed write, so back-to-back instructions have no hazard.
- Latency from accept edge to done: 2 cycles, or 3 for SWAP. Throughput is one instruction per 2 cycles, or 3 for SWAP.
- ovf_flag is updated only on ADD, SUB and MUL:
  - ADD: set when the operand signs are equal and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from op1.
  - MUL: ovf_flag <= alu_o.
- Arithmetic is two's complement and truncated to 16 bits. DIV/remainder follow signed truncation toward zero.
- instr is ignored while instr_ready=0. instr_valid held high across done causes a new accept in the done cycle.

Test Plan:
- Reset held 2 cycles -> instr_ready=1, done=0, ovf_flag=0, rem_reg=0, dbg_data=0 for all 16 addresses.
- LDI r1=0x05; LDI r2=0xFD; ADD r3=r1+r2 -> dbg r2=0xFFFD, r3=0x0002, ovf_flag=0, done 2 cycles after each accept, instr_valid held high gives back-to-back accepts in the done cycles.
- Build r6=0x4000 (LDI 0x40, MUL to 0x1000, ADD twice); ADD r7=r6+r6 -> r7=0x8000, ovf_flag=1; then SUB r8=r7-r7 -> 0x0000, ovf_flag=0.
- r1=0x0007, r2=0xFFFE; DIV r3=r1/r2 -> r3=0xFFFD, rem_reg=0x0001, err=0; DIV r4=r1/r0 (r0=0) -> err=1 with done, r4 and rem_reg unchanged.
- r1=0x0005, r2=0xFFFD; SWAP rd=r1 rs=r2 -> r1=0xFFFD, r2=0x0005, done 3 cycles after accept; SWAP rd=r5 rs=r5 -> r5 unchanged.
- Reset asserted in the SWAP2 cycle -> next cycle IDLE, all registers 0, no done; opcode 0xF -> err=1, done=1, no register changes.
